// File: rtl/vscpu_boot_controller.sv
// rtl/vscpu_boot_controller.sv - loads a program image into RAM, then runs the CPU for a bounded cycle count
module vscpu_boot_controller #(
    parameter int SIZE       = 14,
    parameter int MAX_CYCLES = 100000,
    parameter int CNT_W      = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            cpu_rst,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data,
    output logic            busy,
    output logic            done,
    output logic [SIZE:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_BYTE,
        S_WRITE,
        S_RUN,
        S_DONE
    } state_e;

    // Header counts are 16 bits; compare against the RAM depth in a width that holds both.
    localparam int            CW    = (SIZE + 1 > 16) ? SIZE + 1 : 16;
    localparam logic [SIZE:0] N_MAX = {1'b1, {SIZE{1'b0}}};

    state_e          state_q, state_d;
    logic [7:0]      count_hi_q, count_hi_d;
    logic [SIZE:0]   n_q, n_d;
    logic [31:0]     word_q, word_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [SIZE-1:0] load_addr_q, load_addr_d;
    logic [SIZE:0]   words_q, words_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

    logic [CW-1:0]   count_ext;
    logic [SIZE:0]   n_clamped;
    logic            xfer;

    assign count_ext    = CW'({count_hi_q, in_data});
    assign n_clamped    = (count_ext > CW'(N_MAX)) ? N_MAX : (SIZE + 1)'(count_ext);
    assign xfer         = in_valid && in_ready;
    assign words_loaded = words_q;

    // State and datapath registers; reset aborts any load or run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_hi_q  <= '0;
            n_q         <= '0;
            word_q      <= '0;
            byte_idx_q  <= '0;
            load_addr_q <= '0;
            words_q     <= '0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_hi_q  <= count_hi_d;
            n_q         <= n_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            load_addr_q <= load_addr_d;
            words_q     <= words_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    // Next-state logic, byte intake handshake, CPU reset and the RAM ownership mux.
    always_comb begin
        state_d     = state_q;
        count_hi_d  = count_hi_q;
        n_d         = n_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        load_addr_d = load_addr_q;
        words_d     = words_q;
        run_cnt_d   = run_cnt_q;
        in_ready    = 1'b0;
        cpu_rst     = 1'b1;
        ram_wrEn    = 1'b0;
        ram_addr    = '0;
        ram_data    = '0;
        busy        = 1'b1;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d     = S_HDR_HI;
                    words_d     = '0;
                    load_addr_d = '0;
                    byte_idx_d  = '0;
                end
            end
            S_HDR_HI: begin
                in_ready = 1'b1;
                if (xfer) begin
                    count_hi_d = in_data;
                    state_d    = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    n_d         = n_clamped;
                    byte_idx_d  = '0;
                    load_addr_d = '0;
                    run_cnt_d   = '0;
                    state_d     = (n_clamped == '0) ? S_RUN : S_BYTE;
                end
            end
            S_BYTE: begin
                in_ready = 1'b1;
                if (xfer) begin
                    word_d     = {word_q[23:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                ram_wrEn    = 1'b1;
                ram_addr    = load_addr_q;
                ram_data    = word_q;
                load_addr_d = load_addr_q + SIZE'(1);
                words_d     = words_q + (SIZE + 1)'(1);
                run_cnt_d   = '0;
                state_d     = ((words_q + (SIZE + 1)'(1)) == n_q) ? S_RUN : S_BYTE;
            end
            S_RUN: begin
                cpu_rst   = 1'b0;
                ram_wrEn  = cpu_wrEn;
                ram_addr  = cpu_addr;
                ram_data  = cpu_data;
                run_cnt_d = run_cnt_q + CNT_W'(1);
                if (run_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    state_d     = S_HDR_HI;
                    words_d     = '0;
                    load_addr_d = '0;
                    byte_idx_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vscpu_boot_controller.sv
// tb/tb_vscpu_boot_controller.sv - randomized self-checking bench for vscpu_boot_controller
module tb_vscpu_boot_controller;

    localparam int SIZE  = 3;
    localparam int MAXC  = 10;
    localparam int CNT_W = 4;
    localparam int DEPTH = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic            cpu_rst;
    logic            cpu_wrEn;
    logic [SIZE-1:0] cpu_addr;
    logic [31:0]     cpu_data;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_data;
    logic            busy;
    logic            done;
    logic [SIZE:0]   words_loaded;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int low_cnt, first_low, last_wr;
    int ea;
    logic [31:0] ed;

    logic [7:0]  img [0:4*DEPTH-1];
    logic [31:0] obs [0:DEPTH-1];
    int          exp_addr [$];
    logic [31:0] exp_data [$];

    vscpu_boot_controller #(.SIZE(SIZE), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_data(ram_data),
        .busy(busy), .done(done), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Random CPU bus activity every cycle; the controller must only pass it through while the CPU runs.
    always @(posedge clk) begin
        #2;
        cpu_wrEn = 1'($urandom);
        cpu_addr = SIZE'($urandom);
        cpu_data = $urandom;
    end

    // RAM-side observer: loader writes must match the expected image order, CPU traffic only in run.
    always @(negedge clk) begin
        if (!cpu_rst) begin
            if (low_cnt == 0) first_low = cyc;
            low_cnt++;
            check_val("run_mux", {ram_wrEn, ram_addr, ram_data, in_ready},
                      {cpu_wrEn, cpu_addr, cpu_data, 1'b0});
        end else if (ram_wrEn) begin
            last_wr = cyc;
            if (exp_addr.size() == 0) begin
                check_val("unexpected_write", 1, 0);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                check_val("load_addr", ram_addr, ea);
                check_val("load_data", ram_data, ed);
            end
            obs[ram_addr] = ram_data;
        end else begin
            check_val("idle_mux", {ram_addr, ram_data}, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("in_ready_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic gap_cycles(input int gap, input bit spam);
        for (int g = 0; g < gap; g++) begin
            start = spam && busy;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic prepare(input int n);
        exp_addr.delete();
        exp_data.delete();
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]});
        end
        for (int a = 0; a < DEPTH; a++) obs[a] = 'x;
        low_cnt   = 0;
        first_low = -1;
        last_wr   = -1;
    endtask

    task automatic run_seq(input int count, input int gap, input bit spam, input bit newimg);
        int n;
        int t;
        logic [15:0] hdr;
        hdr = 16'(count);
        n = (count > DEPTH) ? DEPTH : count;
        if (newimg) foreach (img[i]) img[i] = 8'($urandom);
        prepare(n);
        pulse_start();
        check_val("busy_after_start", busy, 1);
        check_val("done_cleared", done, 0);
        check_val("wl_cleared", words_loaded, 0);
        send_byte(hdr[15:8]);
        gap_cycles(gap, spam);
        send_byte(hdr[7:0]);
        gap_cycles(gap, spam);
        for (int b = 0; b < 4*n; b++) begin
            send_byte(img[b]);
            gap_cycles(gap, spam);
        end
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            start    = spam && busy;
            in_valid = spam && busy;
            t++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check_val("done_reached", done, 1);
        check_val("busy_after_run", busy, 0);
        check_val("cpu_rst_after", cpu_rst, 1);
        check_val("in_ready_done", in_ready, 0);
        check_val("words_loaded", words_loaded, n);
        check_val("run_cycles", low_cnt, MAXC);
        check_val("writes_pending", exp_addr.size(), 0);
        if (n > 0) check_val("run_after_write", first_low - last_wr, 1);
        for (int a = 0; a < n; a++)
            check_val("ram_image", obs[a], {img[4*a], img[4*a+1], img[4*a+2], img[4*a+3]});
        repeat (3) @(negedge clk);
        check_val("done_held", done, 1);
    endtask

    initial begin
        logic [7:0] fixed [0:7];
        int cnt;
        fixed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cpu_wrEn = 1'b0;
        cpu_addr = '0;
        cpu_data = '0;
        low_cnt  = 0;
        exp_addr.delete();
        exp_data.delete();
        #1;
        check_val("rst_cpu_rst", cpu_rst, 1);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_ram_wrEn", ram_wrEn, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_words", words_loaded, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Known two-word image, then the same image with gaps and stray starts.
        foreach (img[i]) img[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) img[i] = fixed[i];
        run_seq(2, 0, 1'b0, 1'b0);
        run_seq(2, 3, 1'b1, 1'b0);

        // Empty image goes straight to run.
        run_seq(0, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of the second word.
        foreach (img[i]) img[i] = 8'($urandom);
        prepare(1);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        for (int b = 0; b < 6; b++) send_byte(img[b]);
        #3;
        rst = 1'b1;
        #1;
        check_val("abort_cpu_rst", cpu_rst, 1);
        check_val("abort_in_ready", in_ready, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_words", words_loaded, 0);
        check_val("abort_wrEn", ram_wrEn, 0);
        check_val("abort_pending", exp_addr.size(), 0);
        check_val("abort_word0", obs[0], {img[0], img[1], img[2], img[3]});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_val("abort_idle", busy, 0);
        run_seq(2, 1, 1'b0, 1'b1);

        // Header larger than the RAM clamps to its depth.
        run_seq(12, 0, 1'b0, 1'b1);

        // Random headers, gaps and stray starts.
        for (int r = 0; r < 8; r++) begin
            cnt = ($urandom_range(0, 3) == 0) ? 16'h0100 + $urandom_range(0, 255) : $urandom_range(0, 10);
            run_seq(cnt, $urandom_range(0, 2), 1'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
